uart_cmd_link: RTL and testbench



---
 rtl/uart_cmd_link.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_cmd_link.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_link.sv
// uart_cmd_link
//   8N1 UART transmitter/receiver plus a 24-bit command assembler.
//   Three consecutive received bytes, first byte most significant, form one
//   command word, which is flagged to the host logic on cmd_rdy.
//
// Parameters:
//   BAUD_DIV  clock cycles per bit period (>= 16)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   RX           serial input (idles high)
//   TX           serial output (idles high)
//   trmt         one-cycle pulse, starts transmission of tx_data
//   tx_data[7:0] byte to transmit, sampled with trmt
//   tx_done      last transmission complete; cleared by trmt
//   clr_cmd_rdy  host acknowledge, clears cmd_rdy
//   cmd[23:0]    assembled command (byte 0 in [23:16])
//   cmd_rdy      a complete command is valid on cmd
//
// Build option:
//   UART_CMD_TIMEOUT_EN  when defined, a partial command is dropped after
//                        16 bit periods without a new byte.
module uart_cmd_link #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic        trmt,
  input  logic [7:0]  tx_data,
  output logic        tx_done,
  input  logic        clr_cmd_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy
);

  localparam int unsigned CW   = $clog2(BAUD_DIV);
  localparam int unsigned HALF = BAUD_DIV / 2;

  // ---------------------------------------------------------------- transmitter
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  tx_state_t tx_state, tx_state_nxt;

  logic [9:0]    tx_shift;
  logic [CW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic          tx_load;
  logic          tx_tick;
  logic          tx_last;

  assign tx_tick = (tx_baud == CW'(BAUD_DIV - 1));
  assign tx_last = (tx_bit == 4'd9);

  always_comb begin
    tx_state_nxt = tx_state;
    tx_load      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (trmt) begin
          tx_load      = 1'b1;
          tx_state_nxt = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (tx_tick && tx_last) tx_state_nxt = TX_IDLE;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_state_nxt;
  end

  // Ones are shifted in behind the frame, so TX rests high once the stop
  // bit has gone out and TX can be taken straight from the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '1;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_done  <= 1'b0;
    end else if (tx_load) begin
      tx_shift <= {1'b1, tx_data, 1'b0};
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_done  <= 1'b0;
    end else if (tx_state == TX_SHIFT) begin
      if (tx_tick) begin
        tx_baud  <= '0;
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_bit   <= tx_bit + 4'd1;
        if (tx_last) tx_done <= 1'b1;
      end else begin
        tx_baud <= tx_baud + CW'(1);
      end
    end
  end

  assign TX = tx_shift[0];

  // ------------------------------------------------------------------- receiver
  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  rx_state_t rx_state, rx_state_nxt;

  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] rx_baud;
  logic [3:0]    rx_bit;
  logic          rx_sample;
  logic          rx_stop;
  logic [7:0]    rx_data;
  logic          rdy;
  logic          clr_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Bit 0 (start) is sampled half a period in; every later bit a full period on.
  assign rx_sample = (rx_bit == 4'd0) ? (rx_baud == CW'(HALF - 1))
                                      : (rx_baud == CW'(BAUD_DIV - 1));
  assign rx_stop   = (rx_state == RX_RECV) && rx_sample && (rx_bit == 4'd9);

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) rx_state_nxt = RX_RECV;
      end
      RX_RECV: begin
        if (rx_sample && (((rx_bit == 4'd0) && rx_s2) || (rx_bit == 4'd9)))
          rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_baud <= '0;
      rx_bit  <= '0;
      rx_data <= '0;
    end else if (rx_state == RX_IDLE) begin
      rx_baud <= '0;
      rx_bit  <= '0;
    end else if (rx_sample) begin
      rx_baud <= '0;
      rx_bit  <= rx_bit + 4'd1;
      if ((rx_bit >= 4'd1) && (rx_bit <= 4'd8)) rx_data <= {rx_s2, rx_data[7:1]};
    end else begin
      rx_baud <= rx_baud + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rdy <= 1'b0;
    else if (rx_stop) rdy <= 1'b1;
    else if (clr_rdy) rdy <= 1'b0;
  end

  // ------------------------------------------------------------------ assembler
  typedef enum logic [1:0] {A_IDLE, A_BYTE1, A_BYTE2} asm_state_t;
  asm_state_t asm_state, asm_state_nxt;

  logic tmo;

  // Every received byte is consumed on the cycle it appears.
  assign clr_rdy = rdy;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned TMO_CYC = 16 * BAUD_DIV;
  localparam int unsigned TW      = $clog2(TMO_CYC);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                tmo_cnt <= '0;
    else if (rdy || (asm_state == A_IDLE))  tmo_cnt <= '0;
    else                                    tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo = (asm_state != A_IDLE) && (tmo_cnt == TW'(TMO_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    asm_state_nxt = asm_state;
    if (rdy) begin
      case (asm_state)
        A_IDLE:  asm_state_nxt = A_BYTE1;
        A_BYTE1: asm_state_nxt = A_BYTE2;
        A_BYTE2: asm_state_nxt = A_IDLE;
        default: asm_state_nxt = A_IDLE;
      endcase
    end else if (tmo) begin
      asm_state_nxt = A_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) asm_state <= A_IDLE;
    else     asm_state <= asm_state_nxt;
  end

  // Completing a command takes priority over a simultaneous host acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd     <= '0;
      cmd_rdy <= 1'b0;
    end else begin
      if (rdy) cmd <= {cmd[15:0], rx_data};
      if (rdy && (asm_state == A_BYTE2))     cmd_rdy <= 1'b1;
      else if (rdy && (asm_state == A_IDLE)) cmd_rdy <= 1'b0;
      else if (clr_cmd_rdy)                  cmd_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_link.sv
// Testbench for uart_cmd_link with BAUD_DIV=16 in TX->RX loopback.
// Reference model: the list of bytes delivered since reset; cmd is the last
// three of them, cmd_rdy follows the position of the byte within a command.
module tb_uart_cmd_link;

  localparam int unsigned B       = 16;
  // Edge (counted from the trmt edge) on which a looped-back byte is consumed.
  localparam int unsigned CONSUME = 3 + B/2 + 9*B + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        RX, TX;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        clr_cmd_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        loop_en, rx_drv;

  assign RX = loop_en ? TX : rx_drv;

  always #5 clk = ~clk;

  uart_cmd_link #(.BAUD_DIV(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .TX         (TX),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [7:0]  hist[$];
  int unsigned pos;
  logic        m_rdy;
  int unsigned n_bytes = 0;
  int unsigned rdy_cycles = 0;

  always @(negedge clk) if (dut.rdy) rdy_cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [23:0] exp_cmd();
    logic [23:0] e = '0;
    for (int i = 0; i < 3; i++)
      if (hist.size() > i) e |= 24'(hist[hist.size() - 1 - i]) << (8 * i);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    hist.delete();
    pos   = 0;
    m_rdy = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit clr_at_consume, input bit poke_trmt);
    logic [9:0] frame;
    frame   = {1'b1, b, 1'b0};
    tx_data = b;
    trmt    = 1'b1;
    tick();
    trmt    = 1'b0;
    check("tx_done_clr", tx_done, 1'b0);
    check("tx_start", TX, 1'b0);
    for (int unsigned c = 1; c <= 10*B; c++) begin
      clr_cmd_rdy = clr_at_consume && (c == CONSUME);
      if (poke_trmt && (c == 3*B)) begin
        trmt    = 1'b1;
        tx_data = ~b;
      end else begin
        trmt = 1'b0;
      end
      tick();
      if ((c % B) == B/2) check("tx_bit", TX, frame[c/B]);
      if (c == 10*B - 1)  check("tx_done_early", tx_done, 1'b0);
    end
    clr_cmd_rdy = 1'b0;
    trmt        = 1'b0;
    check("tx_done", tx_done, 1'b1);
    hist.push_back(b);
    n_bytes++;
    pos = (pos + 1) % 3;
    if (pos == 1) m_rdy = 1'b0;
    if (pos == 0) m_rdy = 1'b1;
    check("cmd", cmd, exp_cmd());
    check("cmd_rdy", cmd_rdy, m_rdy);
  endtask

  task automatic clr_pulse();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    check("clr_cmd_rdy", cmd_rdy, 1'b0);
    check("cmd_after_clr", cmd, exp_cmd());
    tick();
    check("clr_rdy_low", dut.clr_rdy, 1'b0);
  endtask

  task automatic idle_wait(input int unsigned n);
    repeat (n) tick();
`ifdef UART_CMD_TIMEOUT_EN
    if (n >= 16*B) pos = 0;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int unsigned rc;
    bit tx_high;

    rst = 1'b1; trmt = 1'b0; tx_data = '0; clr_cmd_rdy = 1'b0;
    loop_en = 1'b1; rx_drv = 1'b1;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_TX", TX, 1'b1);
    check("rst_tx_done", tx_done, 1'b0);
    check("rst_cmd", cmd, 24'h0);
    check("rst_cmd_rdy", cmd_rdy, 1'b0);
    check("rst_rdy", dut.rdy, 1'b0);
    check("rst_rx_data", dut.rx_data, 8'h0);

    // Directed command and acknowledge
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hE3, 1'b0, 1'b0);
    check("cmd_55AAE3", cmd, 24'h55AAE3);
    clr_pulse();
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b1);
    // Third byte lands on the same edge as the acknowledge: set wins
    send_byte(8'h3C, 1'b1, 1'b0);
    check("set_beats_clr", cmd_rdy, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      send_byte(b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) clr_pulse();
      idle_wait($urandom_range(0, 40));
    end

    // Reset in the middle of a frame and a partial command
    send_byte(8'h12, 1'b0, 1'b0);
    tx_data = 8'h34; trmt = 1'b1;
    tick();
    trmt = 1'b0;
    repeat (5*B) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("mid_rst_cmd", cmd, 24'h0);
    check("mid_rst_cmd_rdy", cmd_rdy, 1'b0);
    check("mid_rst_tx_done", tx_done, 1'b0);
    tx_high = 1'b1;
    for (int k = 0; k < 2*B; k++) begin
      tick();
      if (TX !== 1'b1) tx_high = 1'b0;
    end
    check("mid_rst_tx_idle", tx_high, 1'b1);
    check("mid_rst_rdy", dut.rdy, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 1'b0);

    // One-cycle low glitch on RX while idle
    rc = rdy_cycles;
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (4) tick();
    rx_drv = 1'b0;
    tick();
    rx_drv = 1'b1;
    repeat (2*B) tick();
    loop_en = 1'b1;
    check("glitch_no_rdy", rdy_cycles, rc);
    check("glitch_cmd", cmd, exp_cmd());
    check("glitch_cmd_rdy", cmd_rdy, m_rdy);
    send_byte(8'h9A, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b0, 1'b0);
    send_byte(8'hDE, 1'b0, 1'b0);
    check("after_glitch_cmd", cmd, 24'h9ABCDE);

    // Long gap after a first byte
    send_byte(8'h11, 1'b0, 1'b0);
    idle_wait(20*B);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
`ifdef UART_CMD_TIMEOUT_EN
    check("timeout_cmd", cmd, 24'h223344);
    check("timeout_cmd_rdy", cmd_rdy, 1'b1);
`else
    check("no_timeout_cmd_rdy", cmd_rdy, 1'b0);
`endif

    tick();
    check("rdy_pulses", rdy_cycles, n_bytes);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
